// File: rtl/regbank_access_arbiter_if.sv
// Requester and register-bank signal bundle for regbank_access_arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-bank side.
interface regbank_access_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0,   req1;
  logic              we0,    we1;
  logic [ADDR_W-1:0] rs0,    rs1;
  logic [ADDR_W-1:0] rt0,    rt1;
  logic [ADDR_W-1:0] rd0,    rd1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              done0,  done1;
  logic              wr_err0, wr_err1;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [ADDR_W-1:0] bank_rs, bank_rt, bank_rd;
  logic              bank_write, bank_read;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_data_1, bank_data_2;

  modport slave (
    input  req0, req1, we0, we1, rs0, rs1, rt0, rt1, rd0, rd1, wdata0, wdata1,
    input  bank_data_1, bank_data_2,
    output gnt0, gnt1, done0, done1, wr_err0, wr_err1, rdata_a, rdata_b,
    output bank_rs, bank_rt, bank_rd, bank_write, bank_read, bank_wdata
  );

  modport master (
    output req0, req1, we0, we1, rs0, rs1, rt0, rt1, rd0, rd1, wdata0, wdata1,
    output bank_data_1, bank_data_2,
    input  gnt0, gnt1, done0, done1, wr_err0, wr_err1, rdata_a, rdata_b,
    input  bank_rs, bank_rt, bank_rd, bank_write, bank_read, bank_wdata
  );
endinterface

// File: rtl/regbank_access_arbiter.sv
// Two-port arbiter in front of a single-port, level-strobed register bank.
// Each command takes IDLE (grant+latch) -> ISSUE (strobe) -> COMPLETE (done).
module regbank_access_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  regbank_access_arbiter_if.slave bus_if
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic              owner_q,   owner_d;
  logic              last_q,    last_d;
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] rs_q,      rs_d;
  logic [ADDR_W-1:0] rt_q,      rt_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic win;
  logic any_req;
  logic gnt0_c, gnt1_c;
  logic done0_c, done1_c;
  logic err0_c, err1_c;
  logic bwrite_c, bread_c;

  assign any_req = bus_if.req0 | bus_if.req1;

  // last_q holds the most recently granted port; a tie goes to the other one.
  always_comb begin
    if (bus_if.req0 && bus_if.req1) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      win = bus_if.req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    done0_c   = 1'b0;
    done1_c   = 1'b0;
    err0_c    = 1'b0;
    err1_c    = 1'b0;
    bwrite_c  = 1'b0;
    bread_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
          owner_d = win;
          last_d  = win;
          if (win) begin
            gnt1_c  = 1'b1;
            we_d    = bus_if.we1;
            rs_d    = bus_if.rs1;
            rt_d    = bus_if.rt1;
            rd_d    = bus_if.rd1;
            wdata_d = bus_if.wdata1;
          end else begin
            gnt0_c  = 1'b1;
            we_d    = bus_if.we0;
            rs_d    = bus_if.rs0;
            rt_d    = bus_if.rt0;
            rd_d    = bus_if.rd0;
            wdata_d = bus_if.wdata0;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_COMPLETE;
        if (we_q) begin
          bwrite_c = (rd_q != '0);
        end else begin
          // Bank read is combinational; capturing on the edge into COMPLETE
          // makes rdata valid in the same cycle as done.
          bread_c   = 1'b1;
          rdata_a_d = bus_if.bank_data_1;
          rdata_b_d = bus_if.bank_data_2;
        end
      end

      S_COMPLETE: begin
        state_d = S_IDLE;
        if (owner_q) begin
          done1_c = 1'b1;
          err1_c  = we_q && (rd_q == '0);
        end else begin
          done0_c = 1'b1;
          err0_c  = we_q && (rd_q == '0);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant is combinational from the requests, so hold it low while in reset.
  assign bus_if.gnt0       = gnt0_c & rst_n;
  assign bus_if.gnt1       = gnt1_c & rst_n;
  assign bus_if.done0      = done0_c;
  assign bus_if.done1      = done1_c;
  assign bus_if.wr_err0    = err0_c;
  assign bus_if.wr_err1    = err1_c;
  assign bus_if.rdata_a    = rdata_a_q;
  assign bus_if.rdata_b    = rdata_b_q;
  assign bus_if.bank_rs    = rs_q;
  assign bus_if.bank_rt    = rt_q;
  assign bus_if.bank_rd    = rd_q;
  assign bus_if.bank_wdata = wdata_q;
  assign bus_if.bank_write = bwrite_c;
  assign bus_if.bank_read  = bread_c;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Randomized scoreboard bench for regbank_access_arbiter with a register-array reference model.
module tb_regbank_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FP = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();
  regbank_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(FP)) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(ifc)
  );

  // Register bank: level-strobed write, combinational read, r0 reads zero.
  logic [DW-1:0] bank_mem [32];
  initial for (int i = 0; i < 32; i++) bank_mem[i] = '0;
  always @(posedge clk) if (ifc.bank_write && ifc.bank_rd != 0) bank_mem[ifc.bank_rd] <= ifc.bank_wdata;
  assign ifc.bank_data_1 = bank_mem[ifc.bank_rs];
  assign ifc.bank_data_2 = bank_mem[ifc.bank_rt];

  typedef struct {
    int            port;
    bit            is_wr;
    bit            err;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    int            done_cyc;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] ref_regs [32];
  int            last_win = 1;
  logic [DW-1:0] exp_ra = '0, exp_rb = '0;

  // Pending command per requester
  bit            pend [2];
  bit            p_we [2];
  logic [AW-1:0] p_rs [2], p_rt [2], p_rd [2];
  logic [DW-1:0] p_wd [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic drive_all();
    ifc.req0 = pend[0]; ifc.we0 = p_we[0]; ifc.rs0 = p_rs[0]; ifc.rt0 = p_rt[0];
    ifc.rd0 = p_rd[0]; ifc.wdata0 = p_wd[0];
    ifc.req1 = pend[1]; ifc.we1 = p_we[1]; ifc.rs1 = p_rs[1]; ifc.rt1 = p_rt[1];
    ifc.rd1 = p_rd[1]; ifc.wdata1 = p_wd[1];
  endtask

  task automatic set_cmd(input int p, input bit we, input int rs, input int rt, input int rd,
                         input logic [DW-1:0] wd);
    pend[p] = 1'b1; p_we[p] = we; p_rs[p] = AW'(rs); p_rt[p] = AW'(rt); p_rd[p] = AW'(rd);
    p_wd[p] = wd;
  endtask

  task automatic rand_cmd(input int p);
    set_cmd(p, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom);
  endtask

  // One grant: create requests, wait for grant, predict, scramble inputs, check issue cycle.
  task automatic run_op(input int prob);
    bit got;
    int w;
    exp_t e;
    bit lw;
    logic [AW-1:0] lrs, lrt, lrd;
    logic [DW-1:0] lwd;
    for (int p = 0; p < 2; p++) if (!pend[p] && $urandom_range(0, 99) < prob) rand_cmd(p);
    @(posedge clk); #1; drive_all();
    if (!pend[0] && !pend[1]) return;
    got = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ifc.gnt0 || ifc.gnt1) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout: got no grant want a grant within 12 cycles");
      pend[0] = 0; pend[1] = 0; drive_all();
      return;
    end
    if (pend[0] && pend[1]) w = (FP != 0) ? 0 : (last_win == 1 ? 0 : 1);
    else w = pend[1] ? 1 : 0;
    check("gnt_port", 64'({ifc.gnt1, ifc.gnt0}), (w == 1) ? 64'h2 : 64'h1);
    last_win = w;
    lw = p_we[w]; lrs = p_rs[w]; lrt = p_rt[w]; lrd = p_rd[w]; lwd = p_wd[w];
    e.port = w; e.is_wr = lw; e.err = lw && (lrd == 0);
    if (lw) begin
      if (lrd != 0) ref_regs[lrd] = lwd;
    end else begin
      exp_ra = (lrs == 0) ? '0 : ref_regs[lrs];
      exp_rb = (lrt == 0) ? '0 : ref_regs[lrt];
    end
    e.ra = exp_ra; e.rb = exp_rb; e.done_cyc = cyc + 2;
    sbq.push_back(e);
    @(posedge clk); #1;
    pend[w] = 0;
    p_we[w] = 1'($urandom_range(0, 1)); p_rs[w] = AW'($urandom); p_rt[w] = AW'($urandom);
    p_rd[w] = AW'($urandom); p_wd[w] = $urandom;
    drive_all();
    @(negedge clk);
    check("issue_strobe", 64'({ifc.bank_write, ifc.bank_read}),
          lw ? ((lrd != 0) ? 64'h2 : 64'h0) : 64'h1);
    check("issue_addr", 64'({ifc.bank_rs, ifc.bank_rt, ifc.bank_rd}), 64'({lrs, lrt, lrd}));
    check("issue_wdata", 64'(ifc.bank_wdata), 64'(lwd));
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (ifc.done0 || ifc.done1) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=%b%b want none", ifc.done1, ifc.done0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_port", 64'({ifc.done1, ifc.done0}), (e.port == 1) ? 64'h2 : 64'h1);
        check("wr_err", 64'({ifc.wr_err1, ifc.wr_err0}),
              e.err ? ((e.port == 1) ? 64'h2 : 64'h1) : 64'h0);
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("rdata", {ifc.rdata_a, ifc.rdata_b}, {e.ra, e.rb});
      end
    end else if (ifc.wr_err0 || ifc.wr_err1) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_err_no_done: got wr_err=%b%b want 00", ifc.wr_err1, ifc.wr_err0);
    end
  end

  // Strobe shape monitor: single-cycle pulses, at least two low cycles apart, exclusive.
  int low_cnt = 99;
  always @(negedge clk) begin
    if (ifc.bank_write || ifc.bank_read) begin
      check("strobe_gap", 64'(low_cnt >= 2), 64'h1);
      check("strobe_excl", 64'(ifc.bank_write & ifc.bank_read), 64'h0);
      low_cnt = 0;
    end else begin
      low_cnt = low_cnt + 1;
    end
  end

  initial begin
    bit got;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    pend[0] = 0; pend[1] = 0;
    for (int p = 0; p < 2; p++) begin
      p_we[p] = 0; p_rs[p] = '0; p_rt[p] = '0; p_rd[p] = '0; p_wd[p] = '0;
    end
    drive_all();
    ifc.req0 = 1'b1;
    #12;
    check("reset_ctl", 64'({ifc.gnt0, ifc.gnt1, ifc.done0, ifc.done1, ifc.wr_err0,
                            ifc.wr_err1, ifc.bank_write, ifc.bank_read}), 64'h0);
    check("reset_rdata", {ifc.rdata_a, ifc.rdata_b}, 64'h0);
    check("reset_bank", 64'({ifc.bank_rs, ifc.bank_rt, ifc.bank_rd, ifc.bank_wdata}), 64'h0);
    ifc.req0 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // write r5 then read it back alongside r0
    set_cmd(0, 1, 0, 0, 5, 32'hDEADBEEF); run_op(0);
    set_cmd(0, 0, 5, 0, 0, '0); run_op(0);
    // write to r0 is rejected; r0 still reads zero
    set_cmd(1, 1, 0, 0, 0, 32'h1234); run_op(0);
    set_cmd(1, 0, 0, 5, 0, '0); run_op(0);
    // both requesters held for several grants
    for (int k = 0; k < 4; k++) run_op(100);
    pend[0] = 0; pend[1] = 0;
    // back-to-back reads
    set_cmd(0, 1, 0, 0, 1, 32'h11111111); run_op(0);
    set_cmd(0, 1, 0, 0, 2, 32'h22222222); run_op(0);
    set_cmd(0, 0, 1, 2, 0, '0); run_op(0);
    set_cmd(0, 0, 2, 1, 0, '0); run_op(0);
    // random traffic
    for (int k = 0; k < 300; k++) run_op(60);
    pend[0] = 0; pend[1] = 0;

    // reset during ISSUE of a write
    for (int t = 0; t < 6 && sbq.size() != 0; t++) @(negedge clk);
    set_cmd(0, 1, 0, 0, 9, 32'hA5A5A5A5);
    @(posedge clk); #1; drive_all();
    got = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ifc.gnt0) begin got = 1; break; end
    end
    check("rst_test_gnt", 64'(got), 64'h1);
    @(posedge clk); #2;
    pend[0] = 0; drive_all();
    check("rst_pre_strobe", 64'(ifc.bank_write), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 64'({ifc.gnt0, ifc.gnt1, ifc.done0, ifc.done1, ifc.wr_err0,
                              ifc.wr_err1, ifc.bank_write, ifc.bank_read}), 64'h0);
    check("rst_mid_rdata", {ifc.rdata_a, ifc.rdata_b}, 64'h0);
    exp_ra = '0; exp_rb = '0; last_win = 1;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    // first tie after reset goes to port 0; aborted write left r9 untouched
    rand_cmd(0); rand_cmd(1); run_op(0);
    pend[0] = 0; pend[1] = 0;
    set_cmd(1, 0, 9, 9, 0, '0); run_op(0);

    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d outstanding want 0", sbq.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
